// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write arbiter.
package rf_pkg;

    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned DATA_W   = 16;

    typedef logic [ADDR_W-1:0] rf_addr_t;
    typedef logic [DATA_W-1:0] rf_data_t;

    // Arbitration mode encodings
    localparam int unsigned PRIO_RR    = 0;
    localparam int unsigned PRIO_FIXED = 1;

endpackage

// File: rtl/rf_rr_arb2.sv
// Two-way arbiter: round-robin (PRIO_RR) or fixed priority with req[0] highest
// (PRIO_FIXED). last_grant resets to 1 so req[0] wins the first contest.
module rf_rr_arb2
    import rf_pkg::*;
#(
    parameter int unsigned PRIO_MODE = PRIO_RR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic last_grant_q, last_grant_d;

    // Grant decision; a lone request always wins, contention uses the mode
    always_comb begin
        if (req == 2'b11) begin
            grant = (PRIO_MODE == PRIO_FIXED || last_grant_q) ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
        last_grant_d = last_grant_q;
        if (grant[0]) last_grant_d = 1'b0;
        if (grant[1]) last_grant_d = 1'b1;
    end

    // last_grant tracks the most recent winner
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: two writeback requesters share one write
// port; the winning write is registered and presented as a one-hot enable plus
// shared data one cycle after acceptance. Widths come from rf_pkg.
// Optional macro RF_WB_BYPASS_EN adds forwarding of the in-flight write to the
// two read ports.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned PRIO_MODE = PRIO_RR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    input  logic [ADDR_W-1:0]   req0_reg,
    input  logic [DATA_W-1:0]   req0_data,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [ADDR_W-1:0]   req1_reg,
    input  logic [DATA_W-1:0]   req1_data,
    output logic                req1_ready,
    output logic [NUM_REGS-1:0] wr_en,
    output logic [DATA_W-1:0]   wr_data,
    output logic                busy
`ifdef RF_WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]   rd_addr1,
    input  logic [ADDR_W-1:0]   rd_addr2,
    input  logic [DATA_W-1:0]   rf_rd1,
    input  logic [DATA_W-1:0]   rf_rd2,
    output logic [DATA_W-1:0]   rd_data1,
    output logic [DATA_W-1:0]   rd_data2
`endif
);

    logic [1:0]          req;
    logic [1:0]          grant;
    logic [ADDR_W-1:0]   sel_reg;
    logic [DATA_W-1:0]   sel_data;
    logic [NUM_REGS-1:0] wr_en_q, wr_en_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                busy_q, busy_d;

    // No acceptance while reset is held
    assign req = {req1_valid, req0_valid} & {2{~rst}};

    rf_rr_arb2 #(
        .PRIO_MODE(PRIO_MODE)
    ) u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .grant(grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Select the winner and build the next write-stage contents
    always_comb begin
        sel_reg   = grant[1] ? req1_reg  : req0_reg;
        sel_data  = grant[1] ? req1_data : req0_data;
        wr_en_d   = '0;
        wr_data_d = wr_data_q;
        busy_d    = |grant;
        // Register 0 is hardwired zero: accept but never enable, keep data bus
        if ((|grant) && (sel_reg != '0)) begin
            wr_en_d[sel_reg] = 1'b1;
            wr_data_d        = sel_data;
        end
    end

    // Write stage register
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q   <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    // Reset also squashes a write already sitting in the stage
    assign wr_en   = rst ? '0 : wr_en_q;
    assign busy    = busy_q & ~rst;
    assign wr_data = wr_data_q;

`ifdef RF_WB_BYPASS_EN
    // Forward the same-cycle write to the read ports; reg 0 always reads zero
    always_comb begin
        rd_data1 = rf_rd1;
        rd_data2 = rf_rd2;
        if (rd_addr1 == '0) begin
            rd_data1 = '0;
        end else if (busy && wr_en[rd_addr1]) begin
            rd_data1 = wr_data;
        end
        if (rd_addr2 == '0) begin
            rd_data2 = '0;
        end else if (busy && wr_en[rd_addr2]) begin
            rd_data2 = wr_data;
        end
    end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: a round-robin and a fixed-priority instance share
// the stimulus; each cycle the expected next-cycle write stage is queued and the
// previous expectation is popped and compared.
module tb_rf_write_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v0, v1;
    logic [3:0]  r0, r1;
    logic [15:0] d0, d1;
    logic [3:0]  rd_addr1, rd_addr2;
    logic [15:0] rf_rd1, rf_rd2;

    logic [1:0]       rdy0, rdy1, busy_o;
    logic [1:0][15:0] wr_en_o, wr_data_o, rd_data1_o, rd_data2_o;

    rf_write_arbiter #(.PRIO_MODE(0)) u_rr (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_reg(r0), .req0_data(d0), .req0_ready(rdy0[0]),
        .req1_valid(v1), .req1_reg(r1), .req1_data(d1), .req1_ready(rdy1[0]),
        .wr_en(wr_en_o[0]), .wr_data(wr_data_o[0]), .busy(busy_o[0])
`ifdef RF_WB_BYPASS_EN
        , .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .rd_data1(rd_data1_o[0]), .rd_data2(rd_data2_o[0])
`endif
    );

    rf_write_arbiter #(.PRIO_MODE(1)) u_fx (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_reg(r0), .req0_data(d0), .req0_ready(rdy0[1]),
        .req1_valid(v1), .req1_reg(r1), .req1_data(d1), .req1_ready(rdy1[1]),
        .wr_en(wr_en_o[1]), .wr_data(wr_data_o[1]), .busy(busy_o[1])
`ifdef RF_WB_BYPASS_EN
        , .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .rd_data1(rd_data1_o[1]), .rd_data2(rd_data2_o[1])
`endif
    );

    typedef struct packed {
        logic [15:0] en;
        logic [15:0] data;
        logic        busy;
        logic        chk_data;
    } exp_t;

    exp_t        sb0[$];
    exp_t        sb1[$];
    logic [1:0]  m_last;
    logic [15:0] m_data [2];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic a_v0, input logic [3:0] a_r0, input logic [15:0] a_d0,
                           input logic a_v1, input logic [3:0] a_r1, input logic [15:0] a_d1);
        v0 = a_v0; r0 = a_r0; d0 = a_d0;
        v1 = a_v1; r1 = a_r1; d1 = a_d1;
    endtask

    task automatic idle();
        set_req(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    endtask

    // One clock: compare the current write stage and readies, queue next stage
    task automatic run_cycle();
        exp_t       e, n;
        logic [1:0] g;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if ((i == 0 && sb0.size() == 0) || (i == 1 && sb1.size() == 0)) begin
                check_eq($sformatf("sb_empty[%0d]", i), 32'd1, 32'd0);
                e = '0;
            end else begin
                e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
            end
            if (rst) begin
                e.en = '0; e.busy = 1'b0; e.chk_data = 1'b0;
            end
            check_eq($sformatf("wr_en[%0d]", i), 32'(wr_en_o[i]), 32'(e.en));
            check_eq($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(e.busy));
            if (e.chk_data) check_eq($sformatf("wr_data[%0d]", i), 32'(wr_data_o[i]), 32'(e.data));
`ifdef RF_WB_BYPASS_EN
            check_eq($sformatf("rd_data1[%0d]", i), 32'(rd_data1_o[i]),
                     32'((rd_addr1 == 4'd0) ? 16'h0 :
                         (e.busy && e.en[rd_addr1]) ? e.data : rf_rd1));
            check_eq($sformatf("rd_data2[%0d]", i), 32'(rd_data2_o[i]),
                     32'((rd_addr2 == 4'd0) ? 16'h0 :
                         (e.busy && e.en[rd_addr2]) ? e.data : rf_rd2));
`endif
            // Expected grant: instance 0 round-robin, instance 1 fixed priority
            if (rst) g = 2'b00;
            else if (v0 && v1) g = (i == 1 || m_last[i]) ? 2'b01 : 2'b10;
            else g = {v1, v0};
            check_eq($sformatf("req0_ready[%0d]", i), 32'(rdy0[i]), 32'(g[0]));
            check_eq($sformatf("req1_ready[%0d]", i), 32'(rdy1[i]), 32'(g[1]));
            n = '0;
            n.chk_data = 1'b1;
            if (rst) begin
                m_last[i] = 1'b1;
                m_data[i] = '0;
            end else if (g != 2'b00) begin
                m_last[i] = g[1];
                n.busy    = 1'b1;
                if ((g[1] ? r1 : r0) != 4'd0) begin
                    n.en      = 16'h1 << (g[1] ? r1 : r0);
                    m_data[i] = g[1] ? d1 : d0;
                end
            end
            n.data = m_data[i];
            if (i == 0) sb0.push_back(n);
            else sb1.push_back(n);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1;
        idle();
        rd_addr1 = 4'd3; rd_addr2 = 4'd0;
        rf_rd1 = 16'h0000; rf_rd2 = 16'h5555;
        m_last = 2'b11;
        m_data[0] = '0; m_data[1] = '0;
        sb0.push_back(exp_t'({16'h0, 16'h0, 1'b0, 1'b1}));
        sb1.push_back(exp_t'({16'h0, 16'h0, 1'b0, 1'b1}));
        run_cycle(); run_cycle();
        rst = 1'b0;

        // Single write after reset
        set_req(1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 16'h0);
        run_cycle();
        idle();
        run_cycle(); run_cycle();

        // Fresh arbitration state, then continuous contention
        rst = 1'b1; run_cycle(); rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_req(1'b1, 4'(k + 1), 16'h1000 + 16'(k), 1'b1, 4'(k + 6), 16'h2000 + 16'(k));
            run_cycle();
        end
        idle(); run_cycle();

        // Held contention, then req0 drops
        set_req(1'b1, 4'd9, 16'hAAAA, 1'b1, 4'd10, 16'hBBBB);
        repeat (3) run_cycle();
        set_req(1'b0, 4'd0, 16'h0, 1'b1, 4'd10, 16'hBBBB);
        run_cycle();
        idle(); run_cycle();

        // Write to hardwired-zero register
        set_req(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 16'hFFFF);
        run_cycle();
        idle(); run_cycle(); run_cycle();

        // Grant then reset in the following cycle
        set_req(1'b1, 4'd7, 16'hA5A5, 1'b0, 4'd0, 16'h0);
        run_cycle();
        idle(); rst = 1'b1; run_cycle();
        rst = 1'b0; run_cycle();
        set_req(1'b1, 4'd11, 16'h0B0B, 1'b1, 4'd12, 16'h0C0C);
        run_cycle();
        idle(); run_cycle();

        // Write to reg 3 (forwarded when the bypass is built)
        set_req(1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 16'h0);
        run_cycle();
        idle(); run_cycle(); run_cycle();

        // Random traffic
        for (int k = 0; k < 24; k++) begin
            set_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom));
            rd_addr1 = 4'($urandom_range(0, 15));
            rf_rd1   = 16'($urandom);
            run_cycle();
        end
        idle(); run_cycle(); run_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
